// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side command/response bundle for one arbiter port
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
);
   logic                    req;
   logic                    wren;
   logic [DATA_WIDTH/8-1:0] wmask;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    gnt;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (output req, wren, wmask, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, wren, wmask, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port SPRAM arbiter, port 0 priority with bounded port 1 starvation
// Optional MEM_ARB_ROUND_ROBIN_EN replaces the wait counter with round-robin on contention.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   mem_port_arbiter_if.slave       m0,
   mem_port_arbiter_if.slave       m1,
   output logic                    mem_wren,
   output logic [DATA_WIDTH/8-1:0] mem_wmask,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);
   logic       m0_gnt;
   logic       m1_gnt;
   logic       m1_wins;
   logic [1:0] rd_pend;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_gnt;

   // On contention the port that did not win last time goes next.
   assign m1_wins = ~last_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (m0_gnt) begin
         last_gnt <= 1'b0;
      end else if (m1_gnt) begin
         last_gnt <= 1'b1;
      end
   end
`else
   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
   logic [3:0] wait_cnt;

   assign m1_wins = (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 4'd0;
      end else if (m1.req & ~m1_gnt) begin
         if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end else begin
         wait_cnt <= 4'd0;
      end
   end
`endif

   assign m0_gnt = ~rst & m0.req & ~(m1.req & m1_wins);
   assign m1_gnt = ~rst & m1.req & (~m0.req | m1_wins);
   assign m0.gnt = m0_gnt;
   assign m1.gnt = m1_gnt;

   // Idle cycles present port 0's fields so the address bus stays quiet.
   assign mem_addr  = m1_gnt ? m1.addr  : m0.addr;
   assign mem_wdata = m1_gnt ? m1.wdata : m0.wdata;
   assign mem_wmask = m1_gnt ? m1.wmask : m0.wmask;
   assign mem_wren  = (m0_gnt & m0.wren) | (m1_gnt & m1.wren);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 2'b00;
      end else begin
         rd_pend <= {m1_gnt & ~m1.wren, m0_gnt & ~m0.wren};
      end
   end

   // A read accepted just before reset must not report data during reset.
   assign m0.rvalid = rd_pend[0] & ~rst;
   assign m1.rvalid = rd_pend[1] & ~rst;
   assign m0.rdata  = mem_rdata;
   assign m1.rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, directed sequences and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_wren;
   logic [3:0]    mem_wmask;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .mem_wren  (mem_wren),
      .mem_wmask (mem_wmask),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] sram   [DEPTH];
   logic [DW-1:0] shadow [DEPTH];

   always @(posedge clk) begin
      if (mem_wren) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      mem_rdata <= sram[mem_addr];
   end

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'h12345678;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Current stimulus
   logic          cur_rst;
   logic          cur_r0, cur_w0, cur_r1, cur_w1;
   logic [AW-1:0] cur_a0, cur_a1;
   logic [3:0]    cur_k0, cur_k1;
   logic [DW-1:0] cur_d0, cur_d1;

   // Reference model state
   int            m_denied;
   int            m_last;
   int            m_pend;
   logic [DW-1:0] m_pend_data;
   int            exp_win;

   // Sampled DUT outputs for directed checks
   logic          s_g0, s_g1, s_rv0, s_rv1, s_wren;
   logic [DW-1:0] s_rd0, s_rd1;

   function automatic int pick_winner();
      if (cur_rst) return -1;
      if (cur_r0 && !cur_r1) return 0;
      if (cur_r1 && !cur_r0) return 1;
      if (!cur_r0 && !cur_r1) return -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return (m_denied >= MW) ? 1 : 0;
`endif
   endfunction

   task automatic run_cycle();
      logic          w_wren;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      logic [3:0]    w_mask;
      rst          = cur_rst;
      m0_if.req    = cur_r0;  m0_if.wren = cur_w0;  m0_if.addr = cur_a0;
      m0_if.wdata  = cur_d0;  m0_if.wmask = cur_k0;
      m1_if.req    = cur_r1;  m1_if.wren = cur_w1;  m1_if.addr = cur_a1;
      m1_if.wdata  = cur_d1;  m1_if.wmask = cur_k1;
      @(negedge clk);
      exp_win = pick_winner();
      w_wren = (exp_win == 1) ? cur_w1 : cur_w0;
      w_addr = (exp_win == 1) ? cur_a1 : cur_a0;
      w_data = (exp_win == 1) ? cur_d1 : cur_d0;
      w_mask = (exp_win == 1) ? cur_k1 : cur_k0;
      s_g0 = m0_if.gnt; s_g1 = m1_if.gnt; s_rv0 = m0_if.rvalid; s_rv1 = m1_if.rvalid;
      s_wren = mem_wren; s_rd0 = m0_if.rdata; s_rd1 = m1_if.rdata;
      chk("m0_gnt", 32'(s_g0), 32'(exp_win == 0));
      chk("m1_gnt", 32'(s_g1), 32'(exp_win == 1));
      chk("mem_wren", 32'(s_wren), 32'(exp_win >= 0 && w_wren));
      chk("mem_addr", 32'(mem_addr), 32'(w_addr));
      chk("mem_wdata", mem_wdata, w_data);
      chk("mem_wmask", 32'(mem_wmask), 32'(w_mask));
      chk("m0_rvalid", 32'(s_rv0), 32'(!cur_rst && m_pend == 0));
      chk("m1_rvalid", 32'(s_rv1), 32'(!cur_rst && m_pend == 1));
      if (!cur_rst && m_pend == 0) chk("m0_rdata", s_rd0, m_pend_data);
      if (!cur_rst && m_pend == 1) chk("m1_rdata", s_rd1, m_pend_data);
      @(posedge clk);
      if (cur_rst) begin
         m_denied = 0; m_last = 1; m_pend = -1;
      end else begin
         if (exp_win == 1 || !cur_r1) m_denied = 0;
         else if (m_denied < MW) m_denied++;
         m_pend = -1;
         if (exp_win >= 0) begin
            m_last = exp_win;
            if (!w_wren) begin
               m_pend = exp_win;
               m_pend_data = shadow[w_addr];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (w_mask[b]) shadow[w_addr][8*b +: 8] = w_data[8*b +: 8];
            end
         end
      end
      #1;
   endtask

   typedef struct {
      logic rst_v;
      logic r0; logic w0; logic [AW-1:0] a0;
      logic r1; logic w1; logic [AW-1:0] a1; logic [3:0] k1; logic [DW-1:0] d1;
      logic e_g0; logic e_g1; logic e_wren; logic e_rv0; logic e_rv1;
      logic chk_rd; logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs[10];

   function automatic bit pattern_m1(input int k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (k % 2) == 1;
`else
      return (k % 5) == 4;
`endif
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom % 8)
         6:       return 14'h3FFF;
         7:       return AW'($urandom);
         default: return AW'($urandom % 8);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         sram[i] = init_word(i);
         shadow[i] = init_word(i);
      end
      m_denied = 0; m_last = 1; m_pend = -1; m_pend_data = '0;
      cur_rst = 1'b1; cur_r0 = 0; cur_w0 = 0; cur_a0 = '0; cur_k0 = '0; cur_d0 = '0;
      cur_r1 = 0; cur_w1 = 0; cur_a1 = '0; cur_k1 = '0; cur_d1 = '0;

      vecs[0] = '{1, 1,0,14'h0010, 0,0,14'h0,     4'h0,  32'h0,        0,0,0,0,0, 0, 32'h0};
      vecs[1] = '{0, 1,0,14'h0010, 0,0,14'h0,     4'h0,  32'h0,        1,0,0,0,0, 0, 32'h0};
      vecs[2] = '{0, 0,0,14'h0000, 0,0,14'h0,     4'h0,  32'h0,        0,0,0,1,0, 1, 32'h12345678};
      vecs[3] = '{0, 0,0,14'h0000, 1,1,14'h3FFF,  4'h3,  32'hDEADBEEF, 0,1,1,0,0, 0, 32'h0};
      vecs[4] = '{0, 0,0,14'h0000, 0,0,14'h0,     4'h0,  32'h0,        0,0,0,0,0, 0, 32'h0};
      vecs[5] = '{0, 1,0,14'h0020, 0,0,14'h0,     4'h0,  32'h0,        1,0,0,0,0, 0, 32'h0};
      vecs[6] = '{0, 0,0,14'h0000, 1,0,14'h0021,  4'h0,  32'h0,        0,1,0,1,0, 1, init_word(32)};
      vecs[7] = '{0, 1,0,14'h0020, 0,0,14'h0,     4'h0,  32'h0,        1,0,0,0,1, 1, init_word(33)};
      vecs[8] = '{0, 0,0,14'h0000, 1,0,14'h3FFF,  4'h0,  32'h0,        0,1,0,1,0, 1, init_word(32)};
      vecs[9] = '{0, 0,0,14'h0000, 0,0,14'h0,     4'h0,  32'h0,        0,0,0,0,1, 1,
                  (init_word(16383) & 32'hFFFF0000) | 32'h0000BEEF};

      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         cur_rst = vecs[i].rst_v;
         cur_r0 = vecs[i].r0; cur_w0 = vecs[i].w0; cur_a0 = vecs[i].a0;
         cur_r1 = vecs[i].r1; cur_w1 = vecs[i].w1; cur_a1 = vecs[i].a1;
         cur_k1 = vecs[i].k1; cur_d1 = vecs[i].d1;
         run_cycle();
         chk($sformatf("vec%0d_g0", i), 32'(s_g0), 32'(vecs[i].e_g0));
         chk($sformatf("vec%0d_g1", i), 32'(s_g1), 32'(vecs[i].e_g1));
         chk($sformatf("vec%0d_wren", i), 32'(s_wren), 32'(vecs[i].e_wren));
         chk($sformatf("vec%0d_rv0", i), 32'(s_rv0), 32'(vecs[i].e_rv0));
         chk($sformatf("vec%0d_rv1", i), 32'(s_rv1), 32'(vecs[i].e_rv1));
         if (vecs[i].chk_rd)
            chk($sformatf("vec%0d_rdata", i), vecs[i].e_rv0 ? s_rd0 : s_rd1, vecs[i].e_rdata);
      end

      // Continuous contention from a clean arbitration state
      cur_r0 = 1; cur_w0 = 0; cur_a0 = 14'h0004; cur_k0 = '0; cur_d0 = '0;
      cur_r1 = 1; cur_w1 = 0; cur_a1 = 14'h0005; cur_k1 = '0; cur_d1 = '0;
      for (int k = 0; k < 12; k++) begin
         run_cycle();
         chk($sformatf("contend%0d_g1", k), 32'(s_g1), 32'(pattern_m1(k)));
         chk($sformatf("contend%0d_g0", k), 32'(s_g0), 32'(!pattern_m1(k)));
      end

      // Read accepted right before reset: rvalid suppressed, arbitration restarts clean
      cur_a0 = 14'h0010;
      run_cycle();
      cur_rst = 1;
      run_cycle();
      chk("rst_g0", 32'(s_g0), 32'd0);
      chk("rst_g1", 32'(s_g1), 32'd0);
      chk("rst_rv0", 32'(s_rv0), 32'd0);
      chk("rst_wren", 32'(s_wren), 32'd0);
      cur_rst = 0;
      for (int k = 0; k < 5; k++) begin
         run_cycle();
         chk($sformatf("postrst%0d_g1", k), 32'(s_g1), 32'(pattern_m1(k)));
         if (k == 0) chk("postrst_rv0", 32'(s_rv0), 32'd0);
      end

      // Randomized traffic; a denied requester holds its command
      for (int n = 0; n < 3000; n++) begin
         bit hold0, hold1;
         hold0 = !cur_rst && cur_r0 && exp_win != 0;
         hold1 = !cur_rst && cur_r1 && exp_win != 1;
         cur_rst = ($urandom % 60) == 0;
         if (!hold0) begin
            cur_r0 = ($urandom % 4) != 0; cur_w0 = $urandom % 2; cur_a0 = rand_addr();
            cur_d0 = $urandom; cur_k0 = 4'($urandom);
         end
         if (!hold1) begin
            cur_r1 = ($urandom % 4) != 0; cur_w1 = $urandom % 2; cur_a1 = rand_addr();
            cur_d1 = $urandom; cur_k1 = 4'($urandom);
         end
         run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
